pdp8_trace_mon: RTL

Synthesizable instruction-trace monitor for the pdp8 core: watches the CPU `state`, `pc`, `mb`, `ac`, `l`, `ion`, `IF` and `DF` outputs and records one entry per fetch into a circular trace buffer. It replaces the simulation-only PC-sampling, cycle-limit and halt-detect logic in the bench with hardware that also works on the board. Entries are read out through a pop port, for example by a UART dumper. It sits beside `pdp8` and `pdp8_io` at the top level and only observes the CPU.

---
 rtl/pdp8_trace_if.sv | 25 ++
 rtl/pdp8_trace_mon.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pdp8_trace_if.sv
// CPU observation bus and trace pop port for pdp8_trace_mon.
// The monitor takes the slave side; the CPU/dumper side is master.
interface pdp8_trace_if;
   logic [3:0]  state;
   logic [11:0] pc;
   logic [11:0] mb;
   logic [11:0] ac;
   logic        l;
   logic        ion;
   logic [2:0]  IF;
   logic [2:0]  DF;
   logic        rd_en;
   logic [43:0] rd_data;
   logic        rd_valid;

   modport master (
      output state, pc, mb, ac, l, ion, IF, DF, rd_en,
      input  rd_data, rd_valid
   );

   modport slave (
      input  state, pc, mb, ac, l, ion, IF, DF, rd_en,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/pdp8_trace_mon.sv
// pdp8 instruction-trace monitor: one entry per fetch into a ring buffer.
// Optional PC-match trigger: define TRACE_PC_MATCH_EN.
module pdp8_trace_mon #(
   parameter int DEPTH_LOG2 = 6,
   parameter int SAMPLE_DIV = 5000,
   parameter int CYC_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   pdp8_trace_if.slave           bus,
   input  logic [1:0]            mode,
   input  logic                  wrap,
   input  logic [CYC_W-1:0]      max_cycles,
`ifdef TRACE_PC_MATCH_EN
   input  logic                  trig_en,
   input  logic [14:0]           trig_pc,
`endif
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  halted,
   output logic                  done,
   output logic [CYC_W-1:0]      cycles
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] ST_F0   = 4'b0000;
   localparam logic [3:0] ST_HALT = 4'b1100;
   localparam logic [DEPTH_LOG2:0] FULL =
      {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [15:0] SAMP_LAST = 16'(SAMPLE_DIV - 1);

   logic [43:0] mem [DEPTH];

   logic                  prev_f0_q, prev_f0_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [15:0]           samp_q, samp_d;
   logic [CYC_W-1:0]      cycles_q, cycles_d;
   logic                  ovf_q, ovf_d;
   logic                  halted_q, halted_d;
   logic                  done_q, done_d;
   logic                  rd_valid_q;
   logic [43:0]           rd_data_q;

   logic        fe, active, fe_act, qual, full, pop;
   logic        cap_req, wr_en, rd_adv, ovf_set;
   logic [CYC_W-1:0] cyc_nxt;
   logic [43:0] entry;

   assign fe     = (bus.state == ST_F0) && !prev_f0_q;
   assign fe_act = fe && active && !(halted_q || done_q);
   assign qual   = samp_q == SAMP_LAST;
   assign full   = count_q == FULL;
   assign pop    = bus.rd_en && (count_q != '0);
   assign entry  = {bus.IF, bus.DF, bus.l, bus.ion,
                    bus.pc, bus.mb, bus.ac};

`ifdef TRACE_PC_MATCH_EN
   logic armed_q, armed_d, arm_hit;
   assign arm_hit = fe && ({bus.IF, bus.pc} == trig_pc);
   assign active  = !trig_en || armed_q || arm_hit;
   assign armed_d = armed_q || arm_hit;

   // Trigger arm latch, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) armed_q <= 1'b0;
      else       armed_q <= armed_d;
   end
`else
   assign active = 1'b1;
`endif

   // Capture decision, buffer bookkeeping and status next-state.
   always_comb begin
      cap_req = 1'b0;
      case (mode)
         2'b01, 2'b11: cap_req = fe_act;
         2'b10:        cap_req = fe_act && qual;
         default:      cap_req = 1'b0;
      endcase

      wr_en   = 1'b0;
      rd_adv  = pop;
      ovf_set = 1'b0;
      if (cap_req) begin
         if (pop || !full) begin
            wr_en = 1'b1;
         end else if (wrap && (mode != 2'b11)) begin
            wr_en   = 1'b1;
            rd_adv  = 1'b1;
            ovf_set = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end

      count_d = count_q;
      if (wr_en && !rd_adv)      count_d = count_q + 1'b1;
      else if (!wr_en && rd_adv) count_d = count_q - 1'b1;

      wr_ptr_d = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_adv ? rd_ptr_q + 1'b1 : rd_ptr_q;

      cyc_nxt  = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
      cycles_d = fe_act ? cyc_nxt : cycles_q;
      done_d   = done_q;
      if (fe_act && (max_cycles != '0) && (cyc_nxt >= max_cycles))
         done_d = 1'b1;

      samp_d = samp_q;
      if (fe_act) samp_d = qual ? 16'd0 : samp_q + 16'd1;

      halted_d  = halted_q || (bus.state == ST_HALT);
      ovf_d     = ovf_q || ovf_set;
      prev_f0_d = bus.state == ST_F0;
   end

   // State registers and registered read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_f0_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         samp_q     <= '0;
         cycles_q   <= '0;
         ovf_q      <= 1'b0;
         halted_q   <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         prev_f0_q  <= prev_f0_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         samp_q     <= samp_d;
         cycles_q   <= cycles_d;
         ovf_q      <= ovf_d;
         halted_q   <= halted_d;
         done_q     <= done_d;
         rd_valid_q <= pop;
         if (pop) rd_data_q <= mem[rd_ptr_q];
      end
   end

   // Trace RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_ptr_q] <= entry;
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign halted       = halted_q;
   assign done         = done_q;
   assign cycles       = cycles_q;

endmodule
